// File: rtl/pyc_store_buffer_if.sv
// -----------------------------------------------------------------------------
// pyc_store_buffer_if
//
// Bundles every non-clock/reset signal of the store buffer.
//   Store input   : in_valid, in_ready, in_addr, in_data, in_strb
//   Memory write  : drain_en, wvalid, waddr, wdata, wstrb
//   Load check    : chk_addr, chk_conflict
//   Occupancy     : count, empty, full
//
// Handshake: a store transfers on a cycle where in_valid && in_ready are both
// high at the rising clock edge. in_ready never depends on in_valid or on a
// same-cycle drain. The producer may drop or change in_valid/in_* at any time;
// only the sampled values at a transfer edge matter. On the write side a
// write is issued exactly on cycles with wvalid high; the memory has no ready.
//
// Modports:
//   slave  : the store buffer itself
//   master : the producer / memory / load-path side
// -----------------------------------------------------------------------------
interface pyc_store_buffer_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
);
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic [STRB_WIDTH-1:0] in_strb;

    logic                  drain_en;
    logic                  wvalid;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;

    logic [ADDR_WIDTH-1:0] chk_addr;
    logic                  chk_conflict;

    logic [CNT_WIDTH-1:0]  count;
    logic                  empty;
    logic                  full;

    modport slave (
        input  in_valid, in_addr, in_data, in_strb, drain_en, chk_addr,
        output in_ready, wvalid, waddr, wdata, wstrb, chk_conflict,
               count, empty, full
    );

    modport master (
        output in_valid, in_addr, in_data, in_strb, drain_en, chk_addr,
        input  in_ready, wvalid, waddr, wdata, wstrb, chk_conflict,
               count, empty, full
    );
endinterface

// File: rtl/pyc_store_buffer.sv
// -----------------------------------------------------------------------------
// pyc_store_buffer
//
// In-order FIFO of byte-masked stores in front of a byte-addressed memory
// write port. Accepts up to one store per cycle, drains one per cycle while
// drain_en is high, and flags (combinationally) any overlap between an
// 8-lane load window at chk_addr and a buffered, enabled store byte.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   sb   : pyc_store_buffer_if.slave (store input, memory write port,
//          load conflict check, occupancy status)
// -----------------------------------------------------------------------------
module pyc_store_buffer #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    pyc_store_buffer_if.slave sb
);
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WINDOW  = ADDR_WIDTH'(STRB_WIDTH);

    // Entry storage; contents are intentionally not reset.
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [STRB_WIDTH-1:0] strb_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0] count_o;
    logic             in_ready_o;
    logic             wvalid_o;
    logic             enq;
    logic             deq;
    logic [DEPTH-1:0] occ;
    logic             conflict;

    // Status is forced to the empty view while rst is high, because the
    // registers themselves only clear at the reset edge.
    assign count_o    = rst ? '0 : count_q;
    assign in_ready_o = !rst && (count_q != DEPTH_C);
    assign wvalid_o   = !rst && (count_q != '0) && sb.drain_en;

    assign enq = sb.in_valid && in_ready_o;
    assign deq = wvalid_o;

    assign sb.in_ready     = in_ready_o;
    assign sb.wvalid       = wvalid_o;
    assign sb.waddr        = addr_q[head_q];
    assign sb.wdata        = data_q[head_q];
    assign sb.wstrb        = strb_q[head_q];
    assign sb.count        = count_o;
    assign sb.empty        = (count_o == '0);
    assign sb.full         = (count_o == DEPTH_C);
    assign sb.chk_conflict = conflict;

    // Entry i is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ({1'b0, PTR_W'(i) - head_q} < count_o);
        end
    end

    // A buffered byte at address a lies inside the window [chk, chk+STRB)
    // exactly when (a - chk) mod 2^ADDR_WIDTH < STRB; this handles wrap.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (occ[i] && strb_q[i][k] &&
                    ((addr_q[i] + ADDR_WIDTH'(k) - sb.chk_addr) < WINDOW)) begin
                    conflict = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // enq already excludes rst, so no store is captured during reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= sb.in_addr;
            data_q[tail_q] <= sb.in_data;
            strb_q[tail_q] <= sb.in_strb;
        end
    end
endmodule
